// File: rtl/zom_pkg.sv
// Shared zombie types and lane geometry: FSM state encoding, row Y table, spawn/house/contact X.
// Latency: none, constants and pure functions only.
// Backpressure: none.
package zom_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WALK  = 3'd1,
    EAT   = 3'd2,
    DYING = 3'd3,
    HOUSE = 3'd4
  } zom_state_t;

  localparam int START_X = 640;
  localparam int HOUSE_X = 40;
  localparam int PLANT_W = 60;

  // Screen Y of each lane, indexed by lane number.
  localparam logic [9:0] ROW_Y [1:5] = '{10'd110, 10'd180, 10'd250, 10'd320, 10'd390};

  // Lane number to Y; lanes outside 1..5 map to 0.
  function automatic logic [9:0] row_y(input logic [2:0] row);
    logic [9:0] y;
    y = '0;
    case (row)
      3'd1:    y = ROW_Y[1];
      3'd2:    y = ROW_Y[2];
      3'd3:    y = ROW_Y[3];
      3'd4:    y = ROW_Y[4];
      3'd5:    y = ROW_Y[5];
      default: y = '0;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Rising-edge detector on the vsync-rate frame_clk; one-cycle tick per frame.
// Latency: tick is combinational on the cycle frame_clk is first seen high.
// Backpressure: none, free-running.
module frame_tick_gen (
  input  logic clk,
  input  logic rst_n,
  input  logic frame_clk,
  output logic tick
);

  logic prev;

  // Remember last cycle's frame_clk level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) prev <= 1'b0;
    else        prev <= frame_clk;
  end

  assign tick = frame_clk & ~prev;

endmodule

// File: rtl/zombie_walker.sv
// One zombie: walks left along its lane, halts and bites at a plant, dies on damage, flags game over at the house.
// Latency: stop/hit/spawn inputs act on the next clock; bite is a registered one-cycle pulse.
// Backpressure: none; optional ZOM_ENRAGE_EN doubles the step once health is at or below half.
module zombie_walker #(
  parameter int STEP_PX         = 1,
  parameter int FRAMES_PER_STEP = 4,
  parameter int ATTACK_PERIOD   = 60,
  parameter int MAX_HP          = 10,
  parameter int DEATH_FRAMES    = 30
) (
  input  logic       MAX10_CLK1_50,
  input  logic       Reset_n,
  input  logic       frame_clk,
  input  logic       spawn,
  input  logic [2:0] spawn_row,
  input  logic [9:0] stopX1,
  input  logic [9:0] stopX2,
  input  logic [9:0] stopX3,
  input  logic [9:0] stopX4,
  input  logic [9:0] stopX5,
  input  logic       hit,
  input  logic [3:0] hit_dmg,
  output logic [9:0] zomX,
  output logic [9:0] zomY,
  output logic       ZomLive,
  output logic [2:0] zom_state,
  output logic       bite,
  output logic [2:0] bite_row,
  output logic       game_over
);
  import zom_pkg::*;

  zom_state_t state;
  logic [2:0] row;
  logic [3:0] hp;
  logic [7:0] step_cnt;
  logic [7:0] bite_cnt;
  logic [7:0] death_cnt;

  logic       tick;
  logic [9:0] stop;
  logic       blocked;
  logic [3:0] hp_after;
  logic       kill;
  logic [9:0] step_px;
  logic       at_house;

  frame_tick_gen u_tick (
    .clk       (MAX10_CLK1_50),
    .rst_n     (Reset_n),
    .frame_clk (frame_clk),
    .tick      (tick)
  );

  // Plant contact test against this lane's stop X, plus damage and step size for this cycle.
  always_comb begin
    stop = '0;
    case (row)
      3'd1:    stop = stopX1;
      3'd2:    stop = stopX2;
      3'd3:    stop = stopX3;
      3'd4:    stop = stopX4;
      3'd5:    stop = stopX5;
      default: stop = '0;
    endcase
    blocked  = (stop != 10'd0) && (stop <= zomX) && ((zomX - stop) <= 10'(PLANT_W));
    hp_after = hp;
    if (hit) hp_after = (hit_dmg >= hp) ? 4'd0 : (hp - hit_dmg);
    kill = hit && ((state == WALK) || (state == EAT)) && (hp_after == 4'd0);
`ifdef ZOM_ENRAGE_EN
    step_px = (hp <= 4'(MAX_HP / 2)) ? 10'(2 * STEP_PX) : 10'(STEP_PX);
`else
    step_px = 10'(STEP_PX);
`endif
    // zomX - step <= HOUSE_X, written without underflow.
    at_house = (zomX <= (10'(HOUSE_X) + step_px));
  end

  // Zombie lifecycle FSM; every output is registered here.
  always_ff @(posedge MAX10_CLK1_50 or negedge Reset_n) begin
    if (!Reset_n) begin
      state     <= IDLE;
      row       <= '0;
      hp        <= '0;
      step_cnt  <= '0;
      bite_cnt  <= '0;
      death_cnt <= '0;
      zomX      <= '0;
      zomY      <= '0;
      ZomLive   <= 1'b0;
      bite      <= 1'b0;
      bite_row  <= '0;
      game_over <= 1'b0;
    end else begin
      bite <= 1'b0;
      case (state)
        IDLE: begin
          if (spawn && (spawn_row >= 3'd1) && (spawn_row <= 3'd5)) begin
            state     <= WALK;
            row       <= spawn_row;
            zomX      <= 10'(START_X);
            zomY      <= row_y(spawn_row);
            hp        <= 4'(MAX_HP);
            step_cnt  <= '0;
            bite_cnt  <= '0;
            death_cnt <= '0;
            ZomLive   <= 1'b1;
          end
        end
        WALK: begin
          hp <= hp_after;
          if (kill) begin
            state     <= DYING;
            death_cnt <= '0;
          end else if (blocked) begin
            state    <= EAT;
            bite_cnt <= '0;
          end else if (tick) begin
            if (step_cnt == 8'(FRAMES_PER_STEP - 1)) begin
              step_cnt <= '0;
              if (at_house) begin
                zomX      <= 10'(HOUSE_X);
                state     <= HOUSE;
                game_over <= 1'b1;
              end else begin
                zomX <= zomX - step_px;
              end
            end else begin
              step_cnt <= step_cnt + 8'd1;
            end
          end
        end
        EAT: begin
          hp <= hp_after;
          if (kill) begin
            // Killing blow wins; any bite due this cycle is dropped.
            state     <= DYING;
            death_cnt <= '0;
          end else if (!blocked) begin
            state    <= WALK;
            step_cnt <= '0;
          end else if (tick) begin
            if (bite_cnt == 8'(ATTACK_PERIOD - 1)) begin
              bite_cnt <= '0;
              bite     <= 1'b1;
              bite_row <= row;
            end else begin
              bite_cnt <= bite_cnt + 8'd1;
            end
          end
        end
        DYING: begin
          if (tick) begin
            if (death_cnt == 8'(DEATH_FRAMES - 1)) begin
              state   <= IDLE;
              ZomLive <= 1'b0;
            end else begin
              death_cnt <= death_cnt + 8'd1;
            end
          end
        end
        HOUSE: begin
          // Terminal until reset.
          zomX      <= 10'(HOUSE_X);
          ZomLive   <= 1'b1;
          game_over <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign zom_state = state;

endmodule

// File: tb/tb_zombie_walker.sv
// Scoreboard bench for zombie_walker: expected state-change and bite events are queued with their frame-tick stamp.
// A monitor pops and compares each event the DUT presents; spot values are checked directly.
// Stimulus is randomised lanes, plant positions, bite counts and damage.
module tb_zombie_walker;

  logic       clk = 1'b0;
  logic       Reset_n;
  logic       frame_clk;
  logic       spawn;
  logic [2:0] spawn_row;
  logic [9:0] stops [1:5];
  logic       hit;
  logic [3:0] hit_dmg;
  logic [9:0] zomX, zomY;
  logic       ZomLive, bite, game_over;
  logic [2:0] zom_state, bite_row;

  int checks = 0;
  int errors = 0;
  int tk = 0;

  typedef struct {
    int kind;  // 0 = state change, 1 = bite
    int st;
    int x;
    int y;
    int live;
    int go;
    int row;
    int t;
  } ev_t;
  ev_t q[$];

  always #5 clk = ~clk;

  zombie_walker dut (
    .MAX10_CLK1_50 (clk),
    .Reset_n       (Reset_n),
    .frame_clk     (frame_clk),
    .spawn         (spawn),
    .spawn_row     (spawn_row),
    .stopX1        (stops[1]),
    .stopX2        (stops[2]),
    .stopX3        (stops[3]),
    .stopX4        (stops[4]),
    .stopX5        (stops[5]),
    .hit           (hit),
    .hit_dmg       (hit_dmg),
    .zomX          (zomX),
    .zomY          (zomY),
    .ZomLive       (ZomLive),
    .zom_state     (zom_state),
    .bite          (bite),
    .bite_row      (bite_row),
    .game_over     (game_over)
  );

  function automatic int ry(input int r);
    return 40 + 70 * r;
  endfunction

  function automatic bit fm(input int e, input int a);
    return (e < 0) || (e == a);
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", nm, act, exp);
    end
  endtask

  task automatic push_ev(input int kind, input int st, input int x, input int y,
                         input int live, input int go, input int row, input int t);
    ev_t e;
    e.kind = kind; e.st = st; e.x = x; e.y = y;
    e.live = live; e.go = go; e.row = row; e.t = t;
    q.push_back(e);
  endtask

  // n frame ticks, two clocks each; optional hit on the last tick's edge.
  task automatic ticks(input int n, input bit hit_last, input int d);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      frame_clk = 1'b1;
      tk++;
      if (hit_last && (i == n - 1)) begin
        hit = 1'b1;
        hit_dmg = 4'(d);
      end
      @(negedge clk);
      frame_clk = 1'b0;
      hit = 1'b0;
    end
  endtask

  task automatic spawn_z(input int r);
    @(negedge clk);
    spawn = 1'b1;
    spawn_row = 3'(r);
    @(negedge clk);
    spawn = 1'b0;
  endtask

  task automatic hit_p(input int d);
    @(negedge clk);
    hit = 1'b1;
    hit_dmg = 4'(d);
    @(negedge clk);
    hit = 1'b0;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    Reset_n = 1'b0;
    @(negedge clk);
    Reset_n = 1'b1;
  endtask

  // Death interval: still live and frozen for 29 ticks, back to IDLE on the 30th.
  task automatic die_out(input int x_frozen);
    ticks(29, 1'b0, 0);
    check("dying_state", zom_state, 3);
    check("dying_live", ZomLive, 1);
    check("dying_x_frozen", zomX, x_frozen);
    push_ev(0, 0, -1, -1, 0, 0, -1, tk + 1);
    ticks(1, 1'b0, 0);
  endtask

  // Monitor: every state change or bite pulse must match the head of the queue.
  initial begin
    int prev_st;
    int kind;
    ev_t e;
    prev_st = 0;
    forever begin
      @(posedge clk);
      #1;
      if (bite || (int'(zom_state) != prev_st)) begin
        kind = bite ? 1 : 0;
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_event kind=%0d st=%0d x=%0d tick=%0d expected=none",
                   kind, zom_state, zomX, tk);
        end else begin
          e = q.pop_front();
          if (!((e.kind == kind) && fm(e.st, int'(zom_state)) && fm(e.x, int'(zomX)) &&
                fm(e.y, int'(zomY)) && fm(e.live, int'(ZomLive)) && fm(e.go, int'(game_over)) &&
                fm(e.row, int'(bite_row)) && (e.t == tk))) begin
            errors++;
            $display("FAIL event actual kind=%0d st=%0d x=%0d y=%0d live=%0d go=%0d row=%0d tick=%0d required kind=%0d st=%0d x=%0d y=%0d live=%0d go=%0d row=%0d tick=%0d",
                     kind, zom_state, zomX, zomY, ZomLive, game_over, bite_row, tk,
                     e.kind, e.st, e.x, e.y, e.live, e.go, e.row, e.t);
          end
        end
      end
      prev_st = int'(zom_state);
    end
  end

  initial begin
    int x_exp;
    Reset_n = 1'b0;
    frame_clk = 1'b0;
    spawn = 1'b0;
    spawn_row = '0;
    hit = 1'b0;
    hit_dmg = '0;
    for (int j = 1; j <= 5; j++) stops[j] = '0;
    #1;
    check("rst_zomX", zomX, 0);
    check("rst_zomY", zomY, 0);
    check("rst_live", ZomLive, 0);
    check("rst_state", zom_state, 0);
    check("rst_bite", bite, 0);
    check("rst_bite_row", bite_row, 0);
    check("rst_game_over", game_over, 0);
    repeat (2) @(negedge clk);
    Reset_n = 1'b1;

    // Out-of-range lanes are ignored in IDLE.
    spawn_z(0);
    spawn_z(6);
    spawn_z(7);
    check("bad_row_state", zom_state, 0);
    check("bad_row_live", ZomLive, 0);

    // Open lane 3: walk all the way to the house.
    push_ev(0, 1, 640, 250, 1, 0, -1, tk);
    spawn_z(3);
    ticks(8, 1'b0, 0);
    check("walk_8_ticks_x", zomX, 638);
    push_ev(0, 4, 40, 250, 1, 1, -1, tk + 2392);
    ticks(2392, 1'b0, 0);
    spawn_z(2);
    hit_p(15);
    check("house_state", zom_state, 4);
    check("house_x", zomX, 40);
    check("house_game_over", game_over, 1);
    check("house_live", ZomLive, 1);
    push_ev(0, 0, 0, 0, 0, 0, -1, tk);
    pulse_reset();

    // Three hits of 4: 10 -> 6 -> 2 -> 0.
    push_ev(0, 1, 640, 180, 1, 0, -1, tk);
    spawn_z(2);
    hit_p(4);
    hit_p(4);
    push_ev(0, 3, 640, 180, 1, 0, -1, tk);
    hit_p(4);
    die_out(640);
    check("dead_live", ZomLive, 0);
    hit_p(5);
    check("idle_hit_ignored", zom_state, 0);

    // Randomised plant encounters.
    for (int it = 0; it < 6; it++) begin
      int r, stop, bx, k, eat_t, hp, nhp, d, x_now;
      r = $urandom_range(5, 1);
      stop = $urandom_range(579, 480);
      bx = stop + 60;
      for (int j = 1; j <= 5; j++)
        stops[j] = (j == r) ? 10'(stop) : (($urandom_range(1, 0) == 1) ? 10'd600 : 10'd0);
      push_ev(0, 1, 640, ry(r), 1, 0, -1, tk);
      spawn_z(r);
      spawn_z((r % 5) + 1);
      check("spawn_in_walk_y", zomY, ry(r));
      eat_t = tk + (640 - bx) * 4;
      push_ev(0, 2, bx, ry(r), 1, 0, -1, eat_t);
      ticks((640 - bx) * 4, 1'b0, 0);
      k = $urandom_range(2, 1);
      for (int j = 1; j <= k; j++) push_ev(1, 2, bx, ry(r), 1, 0, r, eat_t + 60 * j);
      ticks(60 * k, 1'b0, 0);
      x_now = bx;
      if ((it % 3) == 2) begin
        ticks(59, 1'b0, 0);
        push_ev(0, 3, bx, ry(r), 1, 0, -1, tk + 1);
        ticks(1, 1'b1, 15);
      end else begin
        if ((it % 3) == 0) begin
          push_ev(0, 1, bx, ry(r), 1, 0, -1, tk);
          @(negedge clk);
          stops[r] = '0;
          ticks(4, 1'b0, 0);
          x_now = bx - 1;
          check("resume_walk_x", zomX, x_now);
        end else begin
          ticks($urandom_range(50, 0), 1'b0, 0);
        end
        hp = 10;
        while (hp > 0) begin
          d = $urandom_range(6, 1);
          nhp = (d >= hp) ? 0 : hp - d;
          if (nhp == 0) push_ev(0, 3, x_now, ry(r), 1, 0, -1, tk);
          hit_p(d);
          hp = nhp;
        end
      end
      die_out(x_now);
    end

    // Asynchronous reset while eating, between clock edges.
    for (int j = 1; j <= 5; j++) stops[j] = '0;
    stops[5] = 10'd570;
    push_ev(0, 1, 640, 390, 1, 0, -1, tk);
    spawn_z(5);
    push_ev(0, 2, 630, 390, 1, 0, -1, tk + 40);
    ticks(40, 1'b0, 0);
    ticks(10, 1'b0, 0);
    push_ev(0, 0, 0, 0, 0, 0, -1, tk);
    @(negedge clk);
    #2;
    Reset_n = 1'b0;
    #1;
    check("async_rst_state", zom_state, 0);
    check("async_rst_x", zomX, 0);
    check("async_rst_y", zomY, 0);
    check("async_rst_live", ZomLive, 0);
    check("async_rst_bite", bite, 0);
    check("async_rst_go", game_over, 0);
    @(negedge clk);
    Reset_n = 1'b1;
    stops[5] = '0;

    // Step size at half health.
    push_ev(0, 1, 640, 110, 1, 0, -1, tk);
    spawn_z(1);
    hit_p(5);
    ticks(4, 1'b0, 0);
`ifdef ZOM_ENRAGE_EN
    x_exp = 638;
`else
    x_exp = 639;
`endif
    check("half_hp_step_x", zomX, x_exp);
    push_ev(0, 3, x_exp, 110, 1, 0, -1, tk);
    hit_p(5);
    die_out(x_exp);

    repeat (4) @(negedge clk);
    check("pending_events", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
